// File: rtl/apb_gpio_ioc.sv
// apb_gpio_ioc: APB4 GPIO interrupt-on-change controller.
// Synchronises asynchronous pad inputs, detects rising/falling edges per bit,
// latches enabled edges into a write-1-to-clear PENDING register and raises a
// level interrupt for pending bits that are also enabled in IE.
//
// Ports:
//   PCLK, PRESET              clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE     APB4 control
//   PADDR[2:0]                register word index (0 IE, 1 RISE, 2 FALL,
//                             3 PENDING, 4 STATUS, 5-7 reserved)
//   PSTRB, PWDATA             byte strobes and write data
//   PRDATA                    registered read data
//   PREADY                    tied high (zero wait states)
//   PSLVERR                   combinational error for reserved indices
//   gpio_i                    raw asynchronous pad inputs
//   irq_o                     registered level interrupt request
module apb_gpio_ioc #(
  parameter int unsigned PDATA_SIZE  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [2:0]              PADDR,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [PDATA_SIZE-1:0]   gpio_i,
  output logic                    irq_o
);

  localparam int unsigned W  = PDATA_SIZE;
  localparam int unsigned NB = PDATA_SIZE / 8;

  localparam logic [2:0] ADDR_IE     = 3'd0;
  localparam logic [2:0] ADDR_RISE   = 3'd1;
  localparam logic [2:0] ADDR_FALL   = 3'd2;
  localparam logic [2:0] ADDR_PEND   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  logic [W-1:0]                  ie_q, ie_d;
  logic [W-1:0]                  rise_q, rise_d;
  logic [W-1:0]                  fall_q, fall_d;
  logic [W-1:0]                  pend_q, pend_d;
  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0]                  prev_q, prev_d;
  logic [W-1:0]                  prdata_q, prdata_d;
  logic                          irq_q, irq_d;

  logic         wr;
  logic [W-1:0] be_mask;
  logic [W-1:0] wmask;
  logic [W-1:0] clr;
  logic [W-1:0] sync_out;
  logic [W-1:0] evt;

  // Register state
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ie_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      prdata_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ie_q     <= ie_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      prdata_q <= prdata_d;
      irq_q    <= irq_d;
    end
  end

  // Write decode, edge detection and next-state logic
  always_comb begin
    wr       = PSEL & PENABLE & PWRITE;
    be_mask  = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      be_mask[b*8 +: 8] = {8{PSTRB[b]}};
    end
    wmask    = wr ? be_mask : '0;

    ie_d     = ie_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    clr      = '0;
    unique case (PADDR)
      ADDR_IE:   ie_d   = (ie_q   & ~wmask) | (PWDATA & wmask);
      ADDR_RISE: rise_d = (rise_q & ~wmask) | (PWDATA & wmask);
      ADDR_FALL: fall_d = (fall_q & ~wmask) | (PWDATA & wmask);
      ADDR_PEND: clr    = PWDATA & wmask;
      default:   clr    = '0;
    endcase

    sync_d[0] = gpio_i;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_out = sync_q[SYNC_STAGES-1];
    prev_d   = sync_out;

    evt      = (sync_out & ~prev_q & rise_q) | (~sync_out & prev_q & fall_q);
    // A new event in the same cycle as a clear keeps the bit set
    pend_d   = (pend_q & ~clr) | evt;
    irq_d    = |(pend_q & ie_q);

    unique case (PADDR)
      ADDR_IE:     prdata_d = ie_q;
      ADDR_RISE:   prdata_d = rise_q;
      ADDR_FALL:   prdata_d = fall_q;
      ADDR_PEND:   prdata_d = pend_q;
      ADDR_STATUS: prdata_d = sync_out;
      default:     prdata_d = '0;
    endcase
  end

  assign PRDATA  = prdata_q;
  assign irq_o   = irq_q;
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & (PADDR > ADDR_STATUS);

endmodule
